// File: rtl/seq_divider.sv
// seq_divider: 64-bit signed/unsigned restoring divider, one quotient bit per cycle.
module seq_divider (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_signed,
  input  logic [63:0] dividend,
  input  logic [63:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [63:0] quotient,
  output logic [63:0] remainder,
  output logic        div_by_zero
);
  typedef enum logic [2:0] {IDLE, PREP, DIVIDE, FIX, DONE} state_t;
  state_t state, next;
  logic [63:0] x, y, b, quo, rem, diff;
  logic [64:0] t;
  logic [5:0]  cnt;
  logic        sgn, sign_q, sign_r, dz, ge;
  assign t    = {rem, quo[63]};
  assign ge   = t >= {1'b0, b};
  assign diff = t[63:0] - b;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= next;
  // a zero divisor bypasses DIVIDE but still passes through FIX to load the outputs
  always_comb begin
    next = state;
    unique case (state)
      IDLE:    next = start ? PREP : IDLE;
      PREP:    next = (y == '0) ? FIX : DIVIDE;
      DIVIDE:  next = (cnt == 6'd63) ? FIX : DIVIDE;
      FIX:     next = DONE;
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end
  always_comb begin
    busy = (state == PREP) || (state == DIVIDE) || (state == FIX);
    done = state == DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {x, y, b, quo, rem, cnt, sgn, sign_q, sign_r, dz} <= '0;
      {quotient, remainder, div_by_zero} <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          x   <= dividend;
          y   <= divisor;
          sgn <= is_signed;
        end
        PREP: begin
          quo    <= (y == '0) ? '1 : (sgn && x[63]) ? ~x + 64'd1 : x;
          rem    <= (y == '0) ? x : '0;
          b      <= (sgn && y[63]) ? ~y + 64'd1 : y;
          sign_q <= (y != '0) && sgn && (x[63] ^ y[63]);
          sign_r <= (y != '0) && sgn && x[63];
          dz     <= y == '0;
          cnt    <= '0;
        end
        DIVIDE: begin
          quo <= {quo[62:0], ge};
          rem <= ge ? diff : t[63:0];
          cnt <= cnt + 6'd1;
        end
        FIX: begin
          quotient    <= sign_q ? ~quo + 64'd1 : quo;
          remainder   <= sign_r ? ~rem + 64'd1 : rem;
          div_by_zero <= dz;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed-vector bench for seq_divider with hand-computed results.
module tb_seq_divider;
  logic        clk = 0, rst_n = 0, start = 0, is_signed = 0;
  logic [63:0] dividend = '0, divisor = '0;
  logic        busy, done, div_by_zero;
  logic [63:0] quotient, remainder;
  int total = 0, bad = 0;

  seq_divider dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run(input string tag, input logic s, input logic [63:0] a, input logic [63:0] d,
                     input logic [63:0] eq, input logic [63:0] er, input logic ez,
                     input int lat, input int pulse_at);
    int k, busy_n;
    @(negedge clk);
    is_signed = s; dividend = a; divisor = d; start = 1;
    @(posedge clk); #1;
    start = 0; is_signed = ~s;
    dividend = {$urandom, $urandom}; divisor = {$urandom, $urandom};
    k = 0; busy_n = 0;
    while (!done && k < 200) begin
      if (busy) busy_n++;
      if (k == pulse_at) begin
        start = 1; dividend = 64'd5; divisor = 64'd1;
      end
      @(posedge clk); #1;
      start = 0;
      k++;
    end
    chk({tag, " latency"}, 64'(k), 64'(lat));
    chk({tag, " busy cycles"}, 64'(busy_n), 64'(lat));
    chk({tag, " busy in done"}, 64'(busy), 64'd0);
    chk({tag, " quotient"}, quotient, eq);
    chk({tag, " remainder"}, remainder, er);
    chk({tag, " div_by_zero"}, 64'(div_by_zero), 64'(ez));
    @(posedge clk); #1;
    chk({tag, " done pulse width"}, 64'(done), 64'd0);
    chk({tag, " quotient hold"}, quotient, eq);
  endtask

  initial begin
    #12;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset quotient", quotient, 64'd0);
    chk("reset remainder", remainder, 64'd0);
    chk("reset dz", 64'(div_by_zero), 64'd0);
    @(negedge clk); rst_n = 1;
    run("u100/7", 0, 64'd100, 64'd7, 64'd14, 64'd2, 0, 66, -1);
    run("s-100/7", 1, -64'sd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, 0, 66, -1);
    run("s100/-7", 1, 64'd100, -64'sd7, 64'hFFFF_FFFF_FFFF_FFF2, 64'd2, 0, 66, -1);
    run("s-100/-7", 1, -64'sd100, -64'sd7, 64'd14, 64'hFFFF_FFFF_FFFF_FFFE, 0, 66, -1);
    run("u max/2", 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, 66, -1);
    run("u 7/100", 0, 64'd7, 64'd100, 64'd0, 64'd7, 0, 66, -1);
    run("div0", 0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1, 2, -1);
    run("u9/3", 0, 64'd9, 64'd3, 64'd3, 64'd0, 0, 66, -1);
    run("s ovf", 1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
        64'h8000_0000_0000_0000, 64'd0, 0, 66, -1);
    run("u100/7 restart", 0, 64'd100, 64'd7, 64'd14, 64'd2, 0, 66, 10);
    // abort mid-operation; outputs still hold 14/2 from the previous run
    @(negedge clk);
    is_signed = 0; dividend = 64'd100; divisor = 64'd7; start = 1;
    @(posedge clk); #1; start = 0;
    repeat (30) @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    chk("abort quotient", quotient, 64'd0);
    chk("abort remainder", remainder, 64'd0);
    chk("abort dz", 64'(div_by_zero), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort no done", 64'(done), 64'd0);
    end
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      chk("post-abort idle", 64'(done | busy), 64'd0);
    end
    run("u50/5", 0, 64'd50, 64'd5, 64'd10, 64'd0, 0, 66, -1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
